// File: rtl/wb_master_pkg.sv
// Shared state encoding and bus constants for the Wishbone burst initiator.
package wb_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_BUS,
    ST_PUSH,
    ST_DONE
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
  localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/wb_ack_timer.sv
// Counts cycles a strobe has waited for ack; expire flags the TIMEOUT-th waiting cycle.
// Latency: expire is a decode of the count register, valid in the same cycle.
// Backpressure: none; clear has priority over enable.
module wb_ack_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone classic initiator running a command-driven sequence of single-word transfers.
// Latency: per read word FETCH 1 + BUS (ack wait) + PUSH >= 1 cycles; writes skip PUSH.
// Backpressure: cmd_ready only in IDLE, wr_ready only in FETCH of a write, rd_ready stalls PUSH indefinitely.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic             in_bus;
  logic             expire;
  logic             advance;

  assign in_bus = (state == ST_BUS);

  // A word is finished on a write ack, or when the consumer takes a read word.
  assign advance = (in_bus && wbm_ack_i && wbm_we_o) ||
                   ((state == ST_PUSH) && rd_ready);

  wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_bus),
    .enable (in_bus),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remain    <= '0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            wbm_adr_o <= cmd_addr & ~32'd3;
            remain    <= cmd_len;
            wbm_we_o  <= cmd_we;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wr_ready  <= cmd_we;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!wbm_we_o || wr_valid) begin
            if (wbm_we_o) wbm_dat_o <= wr_data;
            wr_ready  <= 1'b0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= WB_SEL_ALL;
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack takes priority over an expiry in the same cycle.
          if (wbm_ack_i || expire) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= '0;
          end
          if (wbm_ack_i && !wbm_we_o) begin
            rd_data  <= wbm_dat_i;
            rd_valid <= 1'b1;
            state    <= ST_PUSH;
          end else if (!wbm_ack_i && expire) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_PUSH: ;
        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (advance) begin
        rd_valid <= 1'b0;
        if (remain == '0) begin
          done  <= 1'b1;
          state <= ST_DONE;
        end else begin
          remain    <= remain - 1'b1;
          wbm_adr_o <= wbm_adr_o + WORD_STRIDE;
          wr_ready  <= wbm_we_o;
          state     <= ST_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: table of bursts against a delayed-ack BRAM responder,
// plus hand-written sequences for read stall, timeout, late ack and mid-burst reset.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;

  wb_burst_master #(.LEN_W(8), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  always #5 clk = ~clk;

  // BRAM responder: ack on the ack_at-th cycle of a strobe.
  logic [31:0] mem [0:255];
  int          ack_at = 10;
  bit          ack_en = 1'b1;
  int          scnt = 0;

  assign wbm_ack_i = ack_en && wbm_cyc_o && wbm_stb_o && (scnt == ack_at - 1);
  assign wbm_dat_i = mem[wbm_adr_o[9:2]];

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) scnt <= scnt + 1;
    else scnt <= 0;
    if (wbm_ack_i && wbm_we_o) mem[wbm_adr_o[9:2]] <= wbm_dat_o;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_cmd", busy, 1);
    chk("err_clear_on_cmd", err, 0);
  endtask

  task automatic push_wr(input logic [31:0] d);
    int n = 0;
    while (!wr_ready && n < 50) begin @(negedge clk); n++; end
    if (!wr_ready) timeout_fail("wr_ready_wait");
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic bus_word(input logic [31:0] exp_adr, input logic exp_we, input int exp_cycles);
    int n = 0;
    while (!wbm_stb_o && n < 50) begin @(negedge clk); n++; end
    if (!wbm_stb_o) timeout_fail("stb_wait");
    chk("cyc_with_stb", wbm_cyc_o, 1);
    chk("adr", wbm_adr_o, exp_adr);
    chk("we", wbm_we_o, exp_we);
    chk("sel", wbm_sel_o, 4'hF);
    n = 0;
    while (wbm_stb_o && n < 300) begin @(negedge clk); n++; end
    chk("stb_cycles", n, exp_cycles);
  endtask

  task automatic pull_rd(input logic [31:0] exp);
    int n = 0;
    while (!rd_valid && n < 50) begin @(negedge clk); n++; end
    if (!rd_valid) timeout_fail("rd_valid_wait");
    chk("rd_data", rd_data, exp);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic finish_burst(input logic exp_err);
    int n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    if (!done) timeout_fail("done_wait");
    chk("err_at_done", err, exp_err);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("cmd_ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] d0;   // word i carries d0+i
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] base;
    logic [7:0]  idx;

    vecs[0] = '{1'b1, 32'hFFFF_FFFC, 8'd1, 32'h0000_0077};
    vecs[1] = '{1'b1, 32'h3800_0000, 8'd0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h3800_0000, 8'd3, 32'h0000_0001};
    vecs[3] = '{1'b0, 32'h3800_0000, 8'd3, 32'h0000_0001};
    vecs[4] = '{1'b1, 32'h3800_0043, 8'd2, 32'hA5A5_0000};
    vecs[5] = '{1'b0, 32'h3800_0040, 8'd2, 32'hA5A5_0000};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
    chk("rst_we_sel", {wbm_we_o, wbm_sel_o}, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat_o", wbm_dat_o, 0);
    chk("rst_rd_wr", {rd_valid, wr_ready}, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      base = vecs[v].addr & ~32'd3;
      issue_cmd(vecs[v].we, vecs[v].addr, vecs[v].len);
      for (int i = 0; i <= int'(vecs[v].len); i++) begin
        if (vecs[v].we) push_wr(vecs[v].d0 + i);
        bus_word(base + 32'(4 * i), vecs[v].we, 10);
        if (!vecs[v].we) pull_rd(vecs[v].d0 + i);
      end
      finish_burst(1'b0);
      if (vecs[v].we) begin
        for (int i = 0; i <= int'(vecs[v].len); i++) begin
          idx = base[9:2] + 8'(i);
          chk("mem_written", mem[idx], vecs[v].d0 + i);
        end
      end
    end

    // Read stalled by consumer: word held, no new strobe.
    issue_cmd(1'b0, 32'h3800_0000, 8'd1);
    bus_word(32'h3800_0000, 1'b0, 10);
    for (int k = 0; k < 20; k++) begin
      chk("stall_rd_valid", rd_valid, 1);
      chk("stall_rd_data", rd_data, 32'h1);
      chk("stall_no_stb", wbm_stb_o, 0);
      @(negedge clk);
    end
    pull_rd(32'h1);
    bus_word(32'h3800_0004, 1'b0, 10);
    pull_rd(32'h2);
    finish_burst(1'b0);

    // Dead slave: 64-cycle strobe, abort, rest of burst skipped.
    ack_en = 1'b0;
    issue_cmd(1'b1, 32'h3800_0100, 8'd3);
    push_wr(32'h11);
    bus_word(32'h3800_0100, 1'b1, 64);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    @(negedge clk);
    chk("to_done_pulse", done, 0);
    chk("to_idle", {cmd_ready, busy, wr_ready}, 3'b100);
    chk("to_err_sticky", err, 1);
    ack_en = 1'b1;
    issue_cmd(1'b0, 32'h3800_0000, 8'd0);
    bus_word(32'h3800_0000, 1'b0, 10);
    pull_rd(32'h1);
    finish_burst(1'b0);

    // Ack on the last allowed cycle wins over expiry.
    ack_at = 64;
    issue_cmd(1'b1, 32'h3800_0200, 8'd0);
    push_wr(32'h1234_5678);
    bus_word(32'h3800_0200, 1'b1, 64);
    finish_burst(1'b0);
    chk("late_ack_mem", mem[8'h80], 32'h1234_5678);
    ack_at = 10;

    // Reset in the middle of word 2 of 4.
    issue_cmd(1'b1, 32'h3800_0300, 8'd3);
    push_wr(32'h50);
    bus_word(32'h3800_0300, 1'b1, 10);
    push_wr(32'h51);
    chk("rst_mid_in_bus", wbm_stb_o, 1);
    chk("rst_mid_adr", wbm_adr_o, 32'h3800_0304);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid_no_done", done, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("after_rst_no_done", done, 0);
    end
    issue_cmd(1'b0, 32'h3800_0300, 8'd0);
    bus_word(32'h3800_0300, 1'b0, 10);
    pull_rd(32'h50);
    finish_burst(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
